// File: rtl/write_back_unit.sv
`timescale 1ns/1ps
// write_back_unit: retires data-memory results into the register file with an
// edge-triggered handshake. Define WB_BYPASS_EN to add the fwdValid/fwdAddr/fwdData outputs.
module write_back_unit #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 3,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              memoryOperationComplete,
    input  logic [DATA_W-1:0] rdata,
    input  logic              regWrite,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic              regWriteEn,
    output logic [ADDR_W-1:0] regWriteAddr,
    output logic [DATA_W-1:0] regWriteData,
    output logic              resetDataMemory,
    output logic              writeBackComplete,
    output logic [15:0]       retireCount,
    output logic              errTimeout
`ifdef WB_BYPASS_EN
    ,
    output logic              fwdValid,
    output logic [ADDR_W-1:0] fwdAddr,
    output logic [DATA_W-1:0] fwdData
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAPTURE = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam int               CNT_W    = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);

    logic              r_sync1;
    logic              r_sync2;
    logic              r_sync_prev;
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_ack_cnt;
    logic [DATA_W-1:0] r_lat_data;
    logic [ADDR_W-1:0] r_lat_addr;
    logic              r_lat_wr;

    logic              w_rise;
    logic              w_write_ok;
    logic              w_timeout_hit;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  w_ack_cnt_nxt;

    assign w_rise     = r_sync2 & ~r_sync_prev;
    assign w_write_ok = (r_state == S_CAPTURE) && r_lat_wr && (r_lat_addr != {ADDR_W{1'b0}});

    // Two-flop synchronizer plus delayed copy for rising-edge detection.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync1     <= memoryOperationComplete;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
        end
    end

    // Next-state decode; ACK exits on the synchronized drop or on timeout.
    always_comb begin
        w_state_nxt   = r_state;
        w_ack_cnt_nxt = r_ack_cnt;
        w_timeout_hit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_CAPTURE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CAPTURE: begin
                w_state_nxt = S_WRITE;
            end
            S_WRITE: begin
                w_state_nxt   = S_ACK;
                w_ack_cnt_nxt = {CNT_W{1'b0}};
            end
            S_ACK: begin
                if (!r_sync2) begin
                    w_state_nxt = S_DONE;
                end else if (r_ack_cnt == ACK_LAST) begin
                    w_state_nxt   = S_DONE;
                    w_timeout_hit = 1'b1;
                end else begin
                    w_ack_cnt_nxt = r_ack_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and ACK-cycle counter.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= S_IDLE;
            r_ack_cnt <= {CNT_W{1'b0}};
        end else begin
            r_state   <= w_state_nxt;
            r_ack_cnt <= w_ack_cnt_nxt;
        end
    end

    // Operands are sampled as the edge is accepted so the write stage loads purely from latches.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_lat_data <= {DATA_W{1'b0}};
            r_lat_addr <= {ADDR_W{1'b0}};
            r_lat_wr   <= 1'b0;
        end else if ((r_state == S_IDLE) && w_rise) begin
            r_lat_data <= rdata;
            r_lat_addr <= rdAddr;
            r_lat_wr   <= regWrite;
        end
    end

    // Register-file port, handshake outputs, retire counter and sticky timeout flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            regWriteEn        <= 1'b0;
            regWriteAddr      <= {ADDR_W{1'b0}};
            regWriteData      <= {DATA_W{1'b0}};
            resetDataMemory   <= 1'b0;
            writeBackComplete <= 1'b0;
            retireCount       <= 16'd0;
            errTimeout        <= 1'b0;
        end else begin
            regWriteEn        <= w_write_ok;
            resetDataMemory   <= (w_state_nxt == S_ACK);
            writeBackComplete <= (w_state_nxt == S_DONE);
            if (r_state == S_CAPTURE) begin
                regWriteAddr <= r_lat_addr;
                regWriteData <= r_lat_data;
            end
            if (w_state_nxt == S_DONE) begin
                retireCount <= retireCount + 16'd1;
            end
            if (w_timeout_hit) begin
                errTimeout <= 1'b1;
            end
        end
    end

`ifdef WB_BYPASS_EN
    // Forwarding copy of the most recent committed register write.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fwdValid <= 1'b0;
            fwdAddr  <= {ADDR_W{1'b0}};
            fwdData  <= {DATA_W{1'b0}};
        end else if ((r_state == S_WRITE) && regWriteEn) begin
            fwdValid <= 1'b1;
            fwdAddr  <= regWriteAddr;
            fwdData  <= regWriteData;
        end
    end
`endif

endmodule

// File: tb/tb_write_back_unit.sv
`timescale 1ns/1ps
// Scoreboard bench for write_back_unit: stimulus queues expected writes/retires,
// a negedge monitor pops and compares them whenever the DUT presents one.
module tb_write_back_unit;

    logic        clk = 1'b0;
    logic        resetN;
    logic        mop;
    logic [15:0] rdata;
    logic        regWrite;
    logic [2:0]  rdAddr;
    logic        regWriteEn;
    logic [2:0]  regWriteAddr;
    logic [15:0] regWriteData;
    logic        resetDataMemory;
    logic        writeBackComplete;
    logic [15:0] retireCount;
    logic        errTimeout;
`ifdef WB_BYPASS_EN
    logic        fwdValid;
    logic [2:0]  fwdAddr;
    logic [15:0] fwdData;
`endif

    write_back_unit #(.DATA_W(16), .ADDR_W(3), .ACK_TIMEOUT(15)) dut (
        .clk                     (clk),
        .resetN                  (resetN),
        .memoryOperationComplete (mop),
        .rdata                   (rdata),
        .regWrite                (regWrite),
        .rdAddr                  (rdAddr),
        .regWriteEn              (regWriteEn),
        .regWriteAddr            (regWriteAddr),
        .regWriteData            (regWriteData),
        .resetDataMemory         (resetDataMemory),
        .writeBackComplete       (writeBackComplete),
        .retireCount             (retireCount),
        .errTimeout              (errTimeout)
`ifdef WB_BYPASS_EN
        ,
        .fwdValid                (fwdValid),
        .fwdAddr                 (fwdAddr),
        .fwdData                 (fwdData)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wr_q[$];
    logic [15:0] ret_q[$];
    logic [15:0] model_cnt;
    wr_t         mon_wr;
    logic [15:0] mon_ret;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe and retire pulse must match the head of its queue.
    always @(negedge clk) begin
        if (regWriteEn === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr %0d data 0x%0h, expected none", regWriteAddr, regWriteData);
            end else begin
                mon_wr = wr_q.pop_front();
                check("write_addr", 32'(regWriteAddr), 32'(mon_wr.addr));
                check("write_data", 32'(regWriteData), 32'(mon_wr.data));
            end
        end
        if (writeBackComplete === 1'b1) begin
            if (ret_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_retire: got count 0x%0h, expected none", retireCount);
            end else begin
                mon_ret = ret_q.pop_front();
                check("retire_count", 32'(retireCount), 32'(mon_ret));
            end
        end
    end

    task automatic issue(input logic [15:0] d, input logic [2:0] a, input logic w);
        wr_t e;
        rdata    = d;
        rdAddr   = a;
        regWrite = w;
        if (w && (a != 3'd0)) begin
            e.addr = a;
            e.data = d;
            wr_q.push_back(e);
        end
        model_cnt = model_cnt + 16'd1;
        ret_q.push_back(model_cnt);
    endtask

    // sel 0: wait for resetDataMemory, sel 1: wait for writeBackComplete.
    task automatic wait_for(input int sel, input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if ((sel == 0) ? resetDataMemory : writeBackComplete) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL %s: got no event within 60 cycles, expected one", name);
        end
    endtask

    // Upstream that drops its level only after seeing the acknowledge.
    task automatic op_slow(input logic [15:0] d, input logic [2:0] a, input logic w, input bit chk_hold);
        @(negedge clk);
        issue(d, a, w);
        mop = 1'b1;
        wait_for(0, "wait_ack");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (chk_hold) check("ack_held", 32'(resetDataMemory), 32'd1);
        end
        mop = 1'b0;
        wait_for(1, "wait_retire");
        if (chk_hold) check("ack_released", 32'(resetDataMemory), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    // Upstream that pulses its level for two cycles (fastest handshake).
    task automatic op_pulse(input logic [15:0] d, input logic [2:0] a, input logic w, output int lat);
        @(negedge clk);
        issue(d, a, w);
        mop = 1'b1;
        @(negedge clk);
        @(negedge clk);
        mop = 1'b0;
        lat = 2;
        while (!writeBackComplete && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        if (!writeBackComplete) begin
            n_checks++;
            $display("FAIL pulse_retire: got no retire within 60 cycles, expected one");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat;
        int first_err;
        resetN    = 1'b0;
        mop       = 1'b0;
        rdata     = 16'h0000;
        rdAddr    = 3'd0;
        regWrite  = 1'b0;
        model_cnt = 16'd0;

        #12;
        check("rst_we",    32'(regWriteEn),        32'd0);
        check("rst_addr",  32'(regWriteAddr),      32'd0);
        check("rst_data",  32'(regWriteData),      32'd0);
        check("rst_ack",   32'(resetDataMemory),   32'd0);
        check("rst_wbc",   32'(writeBackComplete), 32'd0);
        check("rst_count", 32'(retireCount),       32'd0);
        check("rst_err",   32'(errTimeout),        32'd0);
        @(negedge clk);
        resetN = 1'b1;
        repeat (2) @(negedge clk);

        // Load retire into r3.
        op_slow(16'h1234, 3'd3, 1'b1, 1'b1);
        check("load_count", 32'(retireCount), 32'd1);
        check("load_hold_data", 32'(regWriteData), 32'h1234);

        // Store with the fastest upstream: the pulse lands in the 7th cycle after the raw rise.
        op_pulse(16'hBEEF, 3'd4, 1'b0, lat);
        check("min_latency", 32'(lat + 1), 32'd7);
        check("store_count", 32'(retireCount), 32'd2);

        // r0 write suppressed but retired.
        op_slow(16'hFFFF, 3'd0, 1'b1, 1'b0);
        check("r0_count", 32'(retireCount), 32'd3);

        op_pulse(16'h5A5A, 3'd7, 1'b1, lat);
        check("load7_count", 32'(retireCount), 32'd4);

        // Timeout: level held for 40 cycles; ACK entered at edge 5, 15 ACK cycles -> flag at edge 20.
        @(negedge clk);
        issue(16'h0101, 3'd1, 1'b1);
        mop = 1'b1;
        first_err = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (errTimeout && first_err == 0) first_err = c;
        end
        check("timeout_cycle", 32'(first_err), 32'd20);
        mop = 1'b0;
        repeat (8) @(negedge clk);
        check("timeout_count", 32'(retireCount), 32'd5);
        check("timeout_sticky", 32'(errTimeout), 32'd1);

        op_slow(16'h0C0C, 3'd2, 1'b1, 1'b0);
        check("post_timeout_count", 32'(retireCount), 32'd6);
        check("err_still_set", 32'(errTimeout), 32'd1);

        // Reset asserted while in WRITE: instruction is abandoned.
        @(negedge clk);
        rdata    = 16'h7777;
        rdAddr   = 3'd6;
        regWrite = 1'b1;
        mop      = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("in_write", 32'(regWriteEn), 32'd1);
        resetN = 1'b0;
        #1;
        check("midrst_we",    32'(regWriteEn),        32'd0);
        check("midrst_addr",  32'(regWriteAddr),      32'd0);
        check("midrst_data",  32'(regWriteData),      32'd0);
        check("midrst_ack",   32'(resetDataMemory),   32'd0);
        check("midrst_count", 32'(retireCount),       32'd0);
        check("midrst_err",   32'(errTimeout),        32'd0);
        wr_q.delete();
        mop       = 1'b0;
        model_cnt = 16'd0;
        @(negedge clk);
        resetN = 1'b1;
        repeat (6) @(negedge clk);
        check("resume_count", 32'(retireCount), 32'd0);

        // Wrap: preload the counter near its top instead of running 65535 retires.
        force dut.retireCount = 16'hFFFE;
        @(negedge clk);
        release dut.retireCount;
        model_cnt = 16'hFFFE;
        op_pulse(16'h0002, 3'd1, 1'b1, lat);
        op_pulse(16'h0003, 3'd1, 1'b0, lat);
        check("wrap_count", 32'(retireCount), 32'h0000);

`ifdef WB_BYPASS_EN
        op_slow(16'h00AB, 3'd5, 1'b1, 1'b0);
        check("fwd_valid", 32'(fwdValid), 32'd1);
        check("fwd_addr",  32'(fwdAddr),  32'd5);
        check("fwd_data",  32'(fwdData),  32'h00AB);
        op_pulse(16'h1111, 3'd2, 1'b0, lat);
        check("fwd_hold_valid", 32'(fwdValid), 32'd1);
        check("fwd_hold_addr",  32'(fwdAddr),  32'd5);
        check("fwd_hold_data",  32'(fwdData),  32'h00AB);
`endif

        repeat (5) @(negedge clk);
        check("pending_writes",  32'(wr_q.size()),  32'd0);
        check("pending_retires", 32'(ret_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/write_back_unit.md
WRITE_BACK_UNIT -- requirements
Module: write_back_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning the width of the result/rdata word.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning the register-file address width (8 registers).
REQ-003 SHALL have parameter ACK_TIMEOUT, default 15, meaning the maximum ACK-state cycles allowed before memoryOperationComplete must fall.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port resetN, input, 1 bit: the reset, asynchronous and active-low.
REQ-006 SHALL have port memoryOperationComplete, input, 1 bit: level from the data-memory stage; held high until acknowledged.
REQ-007 SHALL have port rdata, input, DATA_W bits: load data or pass-through result from the data-memory stage.
REQ-008 SHALL have port regWrite, input, 1 bit: the instruction writes a register.
REQ-009 SHALL have port rdAddr, input, ADDR_W bits: the destination register.
REQ-010 SHALL have port regWriteEn, output, 1 bit: register-file write strobe.
REQ-011 SHALL have port regWriteAddr, output, ADDR_W bits: register-file write address.
REQ-012 SHALL have port regWriteData, output, DATA_W bits: register-file write data.
REQ-013 SHALL have port resetDataMemory, output, 1 bit: the acknowledge that clears memoryOperationComplete upstream.
REQ-014 SHALL have port writeBackComplete, output, 1 bit: one-cycle pulse that retires the instruction to fetch.
REQ-015 SHALL have port retireCount, output, 16 bits: count of retired instructions.
REQ-016 SHALL have port errTimeout, output, 1 bit: sticky acknowledge-timeout flag.

Function
REQ-017 SHALL synchronize memoryOperationComplete through two flops and detect its rising edge on the synchronized value.
REQ-018 SHALL implement the states IDLE, CAPTURE, WRITE, ACK and DONE.
REQ-019 IDLE SHALL go to CAPTURE on the synchronized rising edge; otherwise it SHALL stay in IDLE.
REQ-020 CAPTURE SHALL latch rdata, rdAddr and regWrite in one cycle, then go to WRITE.
REQ-021 WRITE SHALL assert regWriteEn for exactly one cycle when the latched regWrite=1 and the latched address is nonzero, with regWriteAddr/regWriteData driven from the latches.
REQ-022 A write to address 0 SHALL be suppressed (r0 stays zero) while the instruction still retires; WRITE SHALL then go to ACK.
REQ-023 ACK SHALL hold resetDataMemory=1 until the synchronized memoryOperationComplete reads 0, then go to DONE.
REQ-024 If ACK persists ACK_TIMEOUT cycles, the block SHALL set errTimeout (cleared only by reset) and go to DONE.
REQ-025 DONE SHALL pulse writeBackComplete for one cycle, increment retireCount (wrapping 0xFFFF->0x0000), and return to IDLE.
REQ-026 Minimum latency from the raw memoryOperationComplete rise to writeBackComplete SHALL be 7 cycles (2 sync, edge, CAPTURE, WRITE, ACK(1 with fast upstream drop), DONE).
REQ-027 A rising edge arriving outside IDLE SHALL be ignored; in IDLE, the level already high after ACK SHALL NOT retrigger (edge-only).
REQ-028 regWriteAddr/regWriteData SHALL hold their last values outside WRITE; regWriteEn SHALL be 0 outside WRITE.

Reset
REQ-029 resetN=0 SHALL asynchronously force IDLE, clear the sync flops, latches, regWriteEn, regWriteAddr, regWriteData, resetDataMemory, writeBackComplete, retireCount and errTimeout to 0.
REQ-030 Reset asserted mid-operation SHALL abandon the instruction with no write, no retire and no count increment; release SHALL resume in IDLE.

Configuration
REQ-031 With WB_BYPASS_EN defined, the block SHALL add outputs fwdValid (1), fwdAddr (ADDR_W) and fwdData (DATA_W), loaded in WRITE whenever regWriteEn=1, held until the next such write, and all reset to 0.
REQ-032 Without WB_BYPASS_EN, those ports and registers SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Load retire: rdata=0x1234, rdAddr=3, regWrite=1, pulse memoryOperationComplete -> one regWriteEn with addr 3/data 0x1234, resetDataMemory high until the input drops, one writeBackComplete, retireCount=1.
REQ-034 Store retire: regWrite=0 -> no regWriteEn, writeBackComplete still pulses, retireCount increments.
REQ-035 r0 suppression: rdAddr=0, regWrite=1, rdata=0xFFFF -> regWriteEn stays 0, instruction retires.
REQ-036 Timeout: hold memoryOperationComplete high for 40 cycles -> errTimeout=1 after 15 ACK cycles, a single retire, and no second capture until the input toggles.
REQ-037 Reset mid-WRITE, plus wrap: resetN low in WRITE -> all outputs 0 immediately; preload 65535 retires then 1 more -> retireCount=0x0000.
REQ-038 Bypass (WB_BYPASS_EN): write 0x00AB to r5 -> fwdValid=1, fwdAddr=5, fwdData=0x00AB, held through a following store.
